// File: rtl/digdug_spatr_shadow.sv
// Sprite attribute store: CPU-visible byte banks plus a double-buffered
// shadow that a VBLANK-triggered copy engine refreshes once per frame.

module digdug_spatr_bank #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] ad,
  input  logic [7:0]    di,
  output logic [7:0]    dt
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[ad] <= di;

  assign dt = mem[ad];
endmodule

module digdug_spatr_shadow #(
  parameter int AW = 7,
  parameter int NB = 3
) (
  input  logic            RCLK,
  input  logic            RESETn,
  input  logic            VBLANK,
  input  logic            CPUCS,
  input  logic            CPUWR,
  input  logic [1:0]      CPUBK,
  input  logic [AW-1:0]   CPUAD,
  input  logic [7:0]      CPUDI,
  output logic [7:0]      CPUDO,
  input  logic [AW-1:0]   SPATAD,
  output logic [8*NB-1:0] SPATDT,
  output logic            BUSY,
  output logic            OVERRUN
);
  typedef enum logic [1:0] {IDLE, RD, WR, SWAP} state_t;

  state_t              state, nxt;
  logic                vblank_q, rise;
  logic [AW-1:0]       cnt, port_ad;
  logic                act;
  logic                busy, do_rd, do_wr, do_swap;
  logic [NB-1:0][7:0]  port_dt, cpy_dt;
  logic [7:0]          cpu_rd;
  logic [8*NB-1:0]     shadow [2**(AW+1)];

  assign rise = VBLANK & ~vblank_q;

  // CPU owns every bank port while CPUCS is high; the copy engine stalls.
  assign port_ad = CPUCS ? CPUAD : cnt;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    digdug_spatr_bank #(.AW(AW)) u_bank (
      .clk (RCLK),
      .we  (CPUCS & CPUWR & (CPUBK == 2'(b))),
      .ad  (port_ad),
      .di  (CPUDI),
      .dt  (port_dt[b])
    );
  end

  always_comb begin
    cpu_rd = '0;
    for (int b = 0; b < NB; b++)
      if (CPUBK == 2'(b)) cpu_rd = port_dt[b];
  end

  always_ff @(posedge RCLK or negedge RESETn)
    if (!RESETn) state <= IDLE;
    else         state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (rise)   nxt = RD;
      RD:   if (!CPUCS) nxt = WR;
      WR:   nxt = (cnt == {AW{1'b1}}) ? SWAP : RD;
      SWAP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    do_rd   = (state == RD) & ~CPUCS;
    do_wr   = (state == WR);
    do_swap = (state == SWAP);
  end

  always_ff @(posedge RCLK or negedge RESETn)
    if (!RESETn) begin
      vblank_q <= 1'b0;
      cnt      <= '0;
      act      <= 1'b0;
      OVERRUN  <= 1'b0;
      CPUDO    <= '0;
      SPATDT   <= '0;
      cpy_dt   <= '0;
    end else begin
      vblank_q <= VBLANK;
      if (state == IDLE && rise)              cnt <= '0;
      else if (do_wr && cnt != {AW{1'b1}})    cnt <= cnt + 1'b1;
      if (do_swap)                            act <= ~act;
      // SWAP still counts as busy, so a rise there is an overrun too.
      if (rise && busy)                       OVERRUN <= 1'b1;
      if (CPUCS && !CPUWR)                    CPUDO <= cpu_rd;
      if (do_rd)                              cpy_dt <= port_dt;
      SPATDT <= shadow[{act, SPATAD}];
    end

  always_ff @(posedge RCLK)
    if (do_wr) shadow[{~act, cnt}] <= cpy_dt;

  assign BUSY = busy;
endmodule

// File: tb/tb_digdug_spatr_shadow.sv
// Directed bench: table-driven CPU accesses, then VBLANK copy sequences
// covering stalls, mid-copy writes, overrun and reset abort.

module tb_digdug_spatr_shadow;
  logic        RCLK = 0, RESETn = 0, VBLANK = 0, CPUCS = 0, CPUWR = 0;
  logic [1:0]  CPUBK = 0;
  logic [6:0]  CPUAD = 0, SPATAD = 0;
  logic [7:0]  CPUDI = 0, CPUDO;
  logic [23:0] SPATDT;
  logic        BUSY, OVERRUN;

  int compared = 0, mismatched = 0;

  digdug_spatr_shadow dut (
    .RCLK(RCLK), .RESETn(RESETn), .VBLANK(VBLANK), .CPUCS(CPUCS),
    .CPUWR(CPUWR), .CPUBK(CPUBK), .CPUAD(CPUAD), .CPUDI(CPUDI),
    .CPUDO(CPUDO), .SPATAD(SPATAD), .SPATDT(SPATDT), .BUSY(BUSY),
    .OVERRUN(OVERRUN)
  );

  always #5 RCLK = ~RCLK;

  typedef struct {
    bit         wr;
    logic [1:0] bk;
    logic [6:0] ad;
    logic [7:0] di;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [16];

  task automatic tick();
    @(posedge RCLK); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu(input bit wr, input logic [1:0] bk, input logic [6:0] ad, input logic [7:0] di);
    CPUCS = 1; CPUWR = wr; CPUBK = bk; CPUAD = ad; CPUDI = di;
    tick();
    CPUCS = 0; CPUWR = 0;
  endtask

  // One VBLANK pulse, then count edges until BUSY drops. Optional CPU
  // stall burst (first cycle writes bank1[0]=55) and a second rise.
  task automatic run_copy(input int stall_at, input int stall_len, input int rise2_at,
                          input bit chk_old, input logic [23:0] old_val, output int n);
    VBLANK = 1;
    tick();
    VBLANK = 0;
    chk("busy_after_rise", BUSY, 1);
    n = 0;
    while (BUSY && n < 1000) begin
      if (n >= stall_at && n < stall_at + stall_len) begin
        CPUCS = 1;
        CPUWR = (n == stall_at);
        CPUBK = (n == stall_at) ? 2'd1 : 2'd2;
        CPUAD = (n == stall_at) ? 7'd0 : 7'd5;
        CPUDI = 8'h55;
      end else begin
        CPUCS = 0; CPUWR = 0;
      end
      VBLANK = (n == rise2_at);
      if (chk_old && (n == 10 || n == 200)) chk("spatdt_during_copy", SPATDT, old_val);
      tick();
      n++;
    end
    CPUCS = 0; CPUWR = 0; VBLANK = 0;
  endtask

  initial begin
    int n;
    tbl[0]  = '{1, 2'd0, 7'd5,   8'hA1, 8'h00};
    tbl[1]  = '{1, 2'd1, 7'd5,   8'hB2, 8'h00};
    tbl[2]  = '{1, 2'd2, 7'd5,   8'hC3, 8'h00};
    tbl[3]  = '{1, 2'd0, 7'd0,   8'h11, 8'h00};
    tbl[4]  = '{1, 2'd1, 7'd0,   8'h22, 8'h00};
    tbl[5]  = '{1, 2'd2, 7'd0,   8'h33, 8'h00};
    tbl[6]  = '{1, 2'd0, 7'd127, 8'h7E, 8'h00};
    tbl[7]  = '{1, 2'd1, 7'd127, 8'h5A, 8'h00};
    tbl[8]  = '{1, 2'd2, 7'd127, 8'hE7, 8'h00};
    tbl[9]  = '{1, 2'd3, 7'd5,   8'hFF, 8'h00};
    tbl[10] = '{0, 2'd0, 7'd5,   8'h00, 8'hA1};
    tbl[11] = '{0, 2'd1, 7'd5,   8'h00, 8'hB2};
    tbl[12] = '{0, 2'd2, 7'd5,   8'h00, 8'hC3};
    tbl[13] = '{0, 2'd3, 7'd5,   8'h00, 8'h00};
    tbl[14] = '{0, 2'd1, 7'd0,   8'h00, 8'h22};
    tbl[15] = '{0, 2'd2, 7'd127, 8'h00, 8'hE7};

    #12;
    chk("rst_cpudo", CPUDO, 0);
    chk("rst_spatdt", SPATDT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_overrun", OVERRUN, 0);
    RESETn = 1;
    tick();

    foreach (tbl[i]) begin
      cpu(tbl[i].wr, tbl[i].bk, tbl[i].ad, tbl[i].di);
      if (!tbl[i].wr) chk($sformatf("cpu_rd[%0d]", i), CPUDO, tbl[i].exp);
    end

    // Copy 1: no stalls.
    SPATAD = 5;
    run_copy(-1, 0, -1, 0, 24'h0, n);
    chk("copy1_busy_cycles", n, 257);
    tick();
    chk("copy1_spat5", SPATDT, 24'hC3B2A1);
    SPATAD = 0;   tick(); chk("copy1_spat0", SPATDT, 24'h332211);
    SPATAD = 127; tick(); chk("copy1_spat127", SPATDT, 24'hE75A7E);

    // Copy 2: new bank0[5], 10-cycle stall starting in RD with a bank1[0] write.
    cpu(1, 2'd0, 7'd5, 8'hD4);
    SPATAD = 5; tick();
    run_copy(20, 10, -1, 1, 24'hC3B2A1, n);
    chk("copy2_busy_cycles", n, 267);
    chk("copy2_swap_cycle_old", SPATDT, 24'hC3B2A1);
    tick();
    chk("copy2_spat5_new", SPATDT, 24'hC3B2D4);
    chk("copy2_stall_cpudo", CPUDO, 8'hC3);
    SPATAD = 0; tick(); chk("copy2_spat0_old_b1", SPATDT, 24'h332211);
    chk("pre_overrun", OVERRUN, 0);

    // Copy 3: second rise at cycle 100 is ignored but sticks OVERRUN.
    run_copy(-1, 0, 99, 0, 24'h0, n);
    chk("copy3_busy_cycles", n, 257);
    chk("copy3_overrun", OVERRUN, 1);
    tick();
    chk("copy3_spat0_b1_55", SPATDT, 24'h335511);
    repeat (5) tick();
    chk("overrun_sticky", OVERRUN, 1);

    // Copy 4: reset at cycle 50 aborts.
    cpu(0, 2'd2, 7'd5, 8'h00);
    chk("pre_rst_cpudo", CPUDO, 8'hC3);
    SPATAD = 5;
    VBLANK = 1; tick(); VBLANK = 0;
    repeat (50) tick();
    chk("mid_copy_busy", BUSY, 1);
    RESETn = 0; #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_spatdt", SPATDT, 0);
    chk("abort_cpudo", CPUDO, 0);
    chk("abort_overrun", OVERRUN, 0);
    #3 RESETn = 1;
    tick();
    cpu(0, 2'd2, 7'd5, 8'h00);
    chk("post_rst_bank2_5", CPUDO, 8'hC3);
    chk("post_rst_idle", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/digdug_spatr_shadow.md
Name: digdug_spatr_shadow

Overview:
- Sprite attribute store upstream of the sprite line renderer.
- Holds the CPU-visible attribute RAM: three byte banks, each 128 bytes, giving 64 sprites × 2 words.
- On each vertical-blank rising edge, a copy engine transfers all 128 entries into the inactive half of a double-buffered 24-bit shadow RAM, then swaps halves.
- The renderer therefore reads a frame-stable {bank2,bank1,bank0} word per address, even while the CPU rewrites attributes mid-frame.

Parameters:
- AW, 7, entry address width (2^AW entries per bank).
- NB, 3, number of CPU byte banks (fixed 3; shadow word width = 8*NB).

Ports:
- RCLK  in  1  rendering clock; all state on rising edge.
- RESETn  in  1  asynchronous active-low reset.
- VBLANK  in  1  vertical blank level, synchronous to RCLK.
- CPUCS  in  1  CPU access strobe to attribute RAM.
- CPUWR  in  1  CPU write enable (qualified by CPUCS).
- CPUBK  in  2  byte bank select: 0,1,2. Value 3 is ignored.
- CPUAD  in  7  entry address.
- CPUDI  in  8  CPU write data.
- CPUDO  out  8  CPU read data, registered.
- SPATAD  in  7  renderer attribute address.
- SPATDT  out  24  renderer attribute word {bank2,bank1,bank0}, registered.
- BUSY  out  1  copy in progress.
- OVERRUN  out  1  sticky: VBLANK edge arrived while BUSY.

Behaviour:
- Reset (async, RESETn=0):
  - Outputs: CPUDO=0, SPATDT=0, BUSY=0, OVERRUN=0.
  - State: ACT=0 (renderer reads shadow half 0), state IDLE, counter CNT=0.
  - RAM contents are not cleared.
- Front RAM:
  - 3×128×8, single port per bank.
  - The CPU has absolute priority on the port of the bank selected by CPUBK whenever CPUCS=1.
- CPU read:
  - CPUCS=1, CPUWR=0 → CPUDO = bank[CPUBK][CPUAD] on the next edge.
  - CPUBK=3 returns 8'h00.
- CPU write: CPUCS=1, CPUWR=1, CPUBK≠3 → the byte is written at the edge.
- Renderer read:
  - Reads shadow half ACT at SPATAD; SPATDT is valid 1 cycle later.
  - This read is never stalled and never sees the half being written.
- VBLANK edge detect: registered VBLANK; rise = VBLANK & ~VBLANK_q.
- Copy FSM:
  - IDLE: on rise → CNT=0, BUSY=1, go to RD.
  - RD:
    - If CPUCS=1 (any bank, any direction), hold in RD (stall) with CNT unchanged.
    - Otherwise read all three banks at CNT and go to WR.
  - WR:
    - Write {b2,b1,b0} to shadow half ~ACT at CNT.
    - If CNT==127 go to SWAP; otherwise CNT=CNT+1 and go to RD.
  - SWAP: ACT toggles, BUSY=0, go to IDLE.
- Timing: minimum copy time is 256 cycles plus 1 swap cycle, i.e. 257 edges from rise to ACT toggle when there are no stalls. Each CPUCS cycle during RD adds exactly 1 cycle.
- CNT is 7 bits; the increment at 127 is not taken (no wrap).
- A CPU write to an entry already copied in this pass appears in the shadow only after the next VBLANK copy.
- A rise while BUSY is ignored (no restart) and sets OVERRUN=1. OVERRUN clears only on reset.
- A rise in the same cycle as SWAP counts as BUSY: the swap completes and OVERRUN is set.
- The renderer sees the new half from the cycle after SWAP. A SPATAD issued in the SWAP cycle returns old-half data.
- Reset mid-copy: the copy is aborted and ACT=0. The partially written half is unspecified until the next full copy.

Test Plan:
- Reset, CPU writes bank0[5]=8'hA1, bank1[5]=8'hB2, bank2[5]=8'hC3. Pulse VBLANK, wait 257 cycles, then SPATAD=5 → SPATDT=24'hC3B2A1 one cycle later; BUSY high exactly 257 cycles.
- During the copy, hold SPATAD=5 (old content 0) → SPATDT stays 24'h000000 until the cycle after SWAP, then reads 24'hC3B2A1.
- Assert CPUCS for 10 cycles mid-copy → ACT toggle occurs at 267 cycles after rise. Shadow contents equal the front RAM as it stood when each entry was read.
- CPU writes bank1[0]=8'h55 after entry 0 is copied but before SWAP → SPATAD=0 shows old bank1 byte this frame and 8'h55 after the next VBLANK copy.
- Second VBLANK rise at cycle 100 of a copy → copy completes at 257 unchanged, OVERRUN=1 and stays 1.
- Drop RESETn at cycle 50 of a copy → BUSY=0, SPATDT=0, CPUDO=0 immediately. After release, CPU read of bank2[5] still returns 8'hC3.
